morse_hex_decoder: RTL and testbench

//  Turns one raw Morse key into hex digits: debounce, dot/dash timing, end-of-letter gap detect, table lookup.

---
 rtl/morse_hex_decoder.sv | 161 ++++++++++++++++
 tb/tb_morse_hex_decoder.sv | 134 +++++++++++++
 2 files changed

// File: rtl/morse_hex_decoder.sv
// Morse key to hex digit decoder: sync, debounce, dot/dash timing, letter gap, table lookup.
// valid/err pulse the cycle after EMIT; code_out holds until the next valid.
module morse_hex_decoder #(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int DASH_CYC     = 30_000_000,
    parameter int GAP_CYC      = 60_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_raw,
    output logic [3:0] code_out,
    output logic       valid,
    output logic       err,
    output logic [2:0] sym_len,
    output logic [4:0] sym_bits,
    output logic       busy
);
    localparam int DBW = $clog2(DEBOUNCE_CYC + 1);
    localparam int DUW = $clog2(DASH_CYC + 1);
    localparam int GPW = $clog2(GAP_CYC + 1);
    localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYC - 1);
    localparam logic [DUW-1:0] DASH_MAX = DUW'(DASH_CYC);
    localparam logic [GPW-1:0] GAP_LAST = GPW'(GAP_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_PRESS, S_GAP, S_EMIT} state_t;

    state_t         state, state_nx;
    logic           key_m, key_s, key_db, key_db_d;
    logic [DBW-1:0] db_cnt;
    logic [DUW-1:0] dur;
    logic [GPW-1:0] gap;
    logic           ovf;
    logic           rise, fall;
    logic           hit;
    logic [3:0]     digit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_m <= 1'b0;
            key_s <= 1'b0;
        end else begin
            key_m <= key_raw;
            key_s <= key_m;
        end
    end

    // Level only moves after key_s has disagreed with it for DEBOUNCE_CYC cycles in a row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_db   <= 1'b0;
            key_db_d <= 1'b0;
            db_cnt   <= '0;
        end else begin
            key_db_d <= key_db;
            if (key_s == key_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                key_db <= key_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign rise = key_db & ~key_db_d;
    assign fall = ~key_db & key_db_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // A rise on the final gap cycle keeps the letter open.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (rise) state_nx = S_PRESS;
            S_PRESS: if (fall) state_nx = S_GAP;
            S_GAP: begin
                if (rise)                 state_nx = S_PRESS;
                else if (gap == GAP_LAST) state_nx = S_EMIT;
            end
            S_EMIT:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != S_IDLE);
        hit   = 1'b1;
        digit = 4'h0;
        case ({sym_len, sym_bits})
            8'b001_00000: digit = 4'hE;
            8'b010_00001: digit = 4'hA;
            8'b011_00100: digit = 4'hD;
            8'b100_01000: digit = 4'hB;
            8'b100_01010: digit = 4'hC;
            8'b100_00010: digit = 4'hF;
            8'b101_11111: digit = 4'h0;
            8'b101_01111: digit = 4'h1;
            8'b101_00111: digit = 4'h2;
            8'b101_00011: digit = 4'h3;
            8'b101_00001: digit = 4'h4;
            8'b101_00000: digit = 4'h5;
            8'b101_10000: digit = 4'h6;
            8'b101_11000: digit = 4'h7;
            8'b101_11100: digit = 4'h8;
            8'b101_11110: digit = 4'h9;
            default:      hit   = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dur      <= '0;
            gap      <= '0;
            ovf      <= 1'b0;
            sym_len  <= 3'd0;
            sym_bits <= 5'd0;
            code_out <= 4'h0;
            valid    <= 1'b0;
            err      <= 1'b0;
        end else begin
            valid <= 1'b0;
            err   <= 1'b0;
            case (state)
                S_IDLE: if (rise) dur <= '0;
                S_PRESS: begin
                    if (fall) begin
                        gap <= '0;
                        if (sym_len < 3'd5) begin
                            sym_bits <= {sym_bits[3:0], (dur >= DASH_MAX)};
                            sym_len  <= sym_len + 3'd1;
                        end else begin
                            ovf <= 1'b1;
                        end
                    end else if (dur != DASH_MAX) begin
                        dur <= dur + 1'b1;
                    end
                end
                S_GAP: begin
                    if (rise) dur <= '0;
                    else      gap <= gap + 1'b1;
                end
                S_EMIT: begin
                    if (hit && !ovf) begin
                        code_out <= digit;
                        valid    <= 1'b1;
                    end else begin
                        err <= 1'b1;
                    end
                    sym_len  <= 3'd0;
                    sym_bits <= 5'd0;
                    ovf      <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_morse_hex_decoder.sv
// Randomized and directed letters checked against a Morse-string reference table.
module tb_morse_hex_decoder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_raw = 1'b0;
    logic [3:0] code_out;
    logic       valid, err, busy;
    logic [2:0] sym_len;
    logic [4:0] sym_bits;

    int n_tests = 0;
    int n_fail  = 0;
    int vcnt = 0, ecnt = 0, both = 0;
    logic [3:0] exp_code = 4'h0;
    string morse [16];

    morse_hex_decoder #(.DEBOUNCE_CYC(4), .DASH_CYC(20), .GAP_CYC(40)) dut (
        .clk(clk), .rst(rst), .key_raw(key_raw), .code_out(code_out), .valid(valid),
        .err(err), .sym_len(sym_len), .sym_bits(sym_bits), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        if (valid) vcnt++;
        if (err) ecnt++;
        if (valid && err) both++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        key_raw = v;
        repeat (n) @(negedge clk);
    endtask

    // syms bit i is the i-th keyed symbol (1 = dash). glitch adds 1-cycle spikes around the first press.
    task automatic send_letter(input string tag, input int n, input logic [7:0] syms, input bit glitch);
        string s;
        int    v0, e0, exp_len, digit;
        logic [4:0] exp_bits;
        s = "";
        exp_bits = 5'd0;
        for (int i = 0; i < n; i++) begin
            s = {s, syms[i] ? "-" : "."};
            if (i < 5) exp_bits = {exp_bits[3:0], syms[i]};
        end
        exp_len = (n > 5) ? 5 : n;
        digit = -1;
        if (n <= 5)
            for (int d = 0; d < 16; d++) if (morse[d] == s) digit = d;

        check({tag, "_code_hold"}, 32'(code_out), 32'(exp_code));
        v0 = vcnt;
        e0 = ecnt;
        if (glitch)
            for (int g = 0; g < 3; g++) begin hold(1'b1, 1); hold(1'b0, 3); end
        for (int i = 0; i < n; i++) begin
            hold(1'b1, syms[i] ? $urandom_range(30, 45) : $urandom_range(6, 12));
            if (i < n - 1) hold(1'b0, $urandom_range(8, 25));
        end
        if (glitch) begin hold(1'b0, 4); hold(1'b1, 1); hold(1'b0, 8); end
        else        hold(1'b0, 12);
        check({tag, "_sym_len"}, 32'(sym_len), 32'(exp_len));
        check({tag, "_sym_bits"}, 32'(sym_bits), 32'(exp_bits));
        check({tag, "_busy_mid"}, 32'(busy), 32'd1);
        hold(1'b0, 60);
        if (digit >= 0) exp_code = 4'(digit);
        check({tag, "_valid_cnt"}, 32'(vcnt - v0), (digit >= 0) ? 32'd1 : 32'd0);
        check({tag, "_err_cnt"}, 32'(ecnt - e0), (digit >= 0) ? 32'd0 : 32'd1);
        check({tag, "_code"}, 32'(code_out), 32'(exp_code));
        check({tag, "_len_clr"}, 32'(sym_len), 32'd0);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int v0, e0;
        morse[0] = "-----"; morse[1] = ".----"; morse[2] = "..---"; morse[3] = "...--";
        morse[4] = "....-"; morse[5] = "....."; morse[6] = "-...."; morse[7] = "--...";
        morse[8] = "---.."; morse[9] = "----."; morse[10] = ".-";   morse[11] = "-...";
        morse[12] = "-.-."; morse[13] = "-..";  morse[14] = ".";    morse[15] = "..-.";

        repeat (3) @(negedge clk);
        rst = 1'b0;
        hold(1'b0, 200);
        check("rst_valid", 32'(vcnt), 32'd0);
        check("rst_err", 32'(ecnt), 32'd0);
        check("rst_code", 32'(code_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_len", 32'(sym_len), 32'd0);

        send_letter("E", 1, 8'b0, 1'b0);
        send_letter("A", 2, 8'b10, 1'b0);
        hold(1'b0, 500);
        check("A_hold500", 32'(code_out), 32'hA);
        send_letter("glitch_E", 1, 8'b0, 1'b1);
        send_letter("five_dash", 5, 8'b11111, 1'b0);
        send_letter("six_dash", 6, 8'b111111, 1'b0);
        send_letter("Q_unknown", 4, 8'b1011, 1'b0);

        // Key is released while reset is still held so nothing restarts afterwards.
        key_raw = 1'b1;
        hold(1'b1, 15);
        rst = 1'b1;
        hold(1'b1, 3);
        check("mid_rst_len", 32'(sym_len), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_code", 32'(code_out), 32'd0);
        check("mid_rst_valid", 32'(valid), 32'd0);
        hold(1'b0, 3);
        rst = 1'b0;
        exp_code = 4'h0;
        v0 = vcnt;
        e0 = ecnt;
        hold(1'b0, 80);
        check("post_rst_valid", 32'(vcnt - v0), 32'd0);
        check("post_rst_err", 32'(ecnt - e0), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);

        for (int k = 0; k < 25; k++)
            send_letter("rand", $urandom_range(1, 6), 8'($urandom), 1'b0);

        check("valid_err_overlap", 32'(both), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
